// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding controller for a 5-stage RV32I pipeline.
// Produces per-stage pipeline-register enables and flushes, EX operand-forward
// selects, and the PC redirect for taken jumps/branches resolved at BR_STAGE.
// Optional build macro: PERF_CNT_EN adds saturating stall/flush counters;
// without it the counter outputs are tied to zero and no counter flops exist.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_wen,
  input  logic              wb_wen,
  input  logic              br_taken,
  input  logic              acki_n,
  input  logic              mreq,
  input  logic              ackd_n,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              redirect,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    LSTALL = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   pending_br_q, pending_br_d;

  logic frozen;
  logic br_req;
  logic load_use;

  // Hazard conditions feeding the priority chain
  always_comb begin
    frozen   = mreq & ackd_n;
    br_req   = br_taken | pending_br_q;
    load_use = ex_is_load & ex_wen & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) |
                (id_use_rs2 & (id_rs2 == ex_rd)));
  end

  // Operand forwarding: MEM result wins over WB; x0 is never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst_n) begin
      if (mem_wen && (mem_rd != '0) && (mem_rd == ex_rs1))
        fwd_a = 2'b01;
      else if (wb_wen && (wb_rd != '0) && (wb_rd == ex_rs1))
        fwd_a = 2'b10;
      if (mem_wen && (mem_rd != '0) && (mem_rd == ex_rs2))
        fwd_b = 2'b01;
      else if (wb_wen && (wb_rd != '0) && (wb_rd == ex_rs2))
        fwd_b = 2'b10;
    end
  end

  // Next state and pipeline controls: D-wait freeze > redirect > load-use > I-wait.
  // While reset is held every output sits at its reset value.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    redirect     = 1'b0;
    state_d      = RUN;
    pending_br_d = pending_br_q;
    if (!rst_n) begin
      pending_br_d = 1'b0;
    end else if (frozen) begin
      // Whole pipe holds; a branch resolved now must survive the freeze
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = DWAIT;
      if (br_taken)
        pending_br_d = 1'b1;
    end else if (br_req) begin
      redirect     = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = (BR_STAGE == 3);
      pending_br_d = 1'b0;
    end else if (load_use && (state_q != LSTALL)) begin
      // Exactly one bubble; the LSTALL guard keeps it from repeating
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LSTALL;
    end else if (acki_n) begin
      // Fetch not ready: hold PC, feed a bubble into ID, let the rest drain
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // State and pending-branch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pending_br_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_br_q <= pending_br_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters of PC-stalled cycles and redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It generates per-stage pipeline-register enables and flushes, plus operand-forwarding selects for EX. It handles load-use hazards, instruction- and data-memory wait states (ACKI_n/ACKD_n), and taken jump/branch redirects at a configurable resolution stage. It sits beside the pipeline registers and drives their enable and flush inputs.

Parameters:
REG_AW, 5, register-address width (log2 of register count)
BR_STAGE, 3, stage resolving jump/branch: 2=EX (flush IF/ID, ID/EX), 3=MEM (also flush EX/MEM)
CNT_W, 16, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
id_rs1, id_rs2  in  REG_AW  source registers of instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  REG_AW  source registers of instruction in EX
ex_rd  in  REG_AW  destination of EX instruction
ex_wen  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load
mem_rd, wb_rd  in  REG_AW  destinations in MEM, WB
mem_wen, wb_wen  in  1  MEM/WB instruction writes rd
br_taken  in  1  taken jump/branch at stage BR_STAGE (single-cycle pulse)
acki_n  in  1  instruction memory not ready
mreq  in  1  MEM stage accesses data memory
ackd_n  in  1  data memory not ready
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
ifid_flush, idex_flush, exmem_flush  out  1  load bubble (NOP, wen=0) instead of input
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 from MEM (c), 10 from WB (data_to_reg)
redirect  out  1  PC mux selects branch target this cycle
stall_cycles, flush_events  out  CNT_W  performance counters (PERF_CNT_EN only)

Behaviour:
- Reset (async, rst_n=0): state=RUN, pending_br=0, all enables 1, all flushes 0, fwd_a/fwd_b=00, redirect=0, counters 0.
- Forwarding (combinational): fwd_a=01 if mem_wen & mem_rd!=0 & mem_rd==ex_rs1; else 10 if wb_wen & wb_rd!=0 & wb_rd==ex_rs1; else 00. MEM has priority over WB. fwd_b is identical on ex_rs2. Writes to x0 are never forwarded.
- State machine states: RUN, DWAIT, LSTALL.
- Priority each cycle: DWAIT freeze > branch redirect > load-use stall > I-wait.
- DWAIT: entered or held while mreq & ackd_n. All five enables 0, no flush. A br_taken seen during DWAIT, or in the cycle DWAIT is entered, sets pending_br. The stalled branch is not lost.
- Redirect: when br_taken or pending_br is set and not frozen: redirect=1, pc_en=1, flush the younger stages (ifid_flush, idex_flush; exmem_flush too when BR_STAGE=3). Clear pending_br. Any load-use stall or I-wait in the same cycle is discarded.
- Load-use: ex_is_load & ex_wen & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)) gives exactly one bubble: pc_en=0, ifid_en=0, idex_flush=1. Go to LSTALL for one cycle, then return to RUN. Because ex now holds the bubble, the stall does not re-trigger.
- I-wait: acki_n=1 and none of the above: pc_en=0, ifid_flush=1; ID and later stages advance.
- Redirect latency: br_taken is consumed the same cycle (combinational). A pending_br is consumed the first cycle after ackd_n drops.
- rst_n asserted mid-stall or with a pending branch: all state is discarded and outputs go to reset values immediately.

Optional Feature:
PERF_CNT_EN: when defined, stall_cycles increments on every cycle with pc_en=0, and flush_events increments on every redirect. Both saturate at all-ones and reset to 0. When undefined, both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Forward priority: ex_rs1=5, mem_rd=5/mem_wen=1, wb_rd=5/wb_wen=1 -> fwd_a=01. With mem_wen=0 -> fwd_a=10. With rd=0 -> fwd_a=00.
- Load-use: ex_is_load=1, ex_rd=7, id_rs1=7, id_use_rs1=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Next cycle (ex_is_load=0) all enables 1.
- D-wait with branch: mreq=1, ackd_n=1 for 3 cycles, br_taken pulsed in cycle 1 -> enables 0 for 3 cycles, no flush. The cycle ackd_n=0 gives redirect=1, ifid_flush=1, idex_flush=1, exmem_flush=1 (BR_STAGE=3).
- Branch beats load-use: br_taken=1 with a load-use match -> redirect=1 with flushes, pc_en=1, no LSTALL entry.
- I-wait: acki_n=1 for 2 cycles -> pc_en=0, ifid_flush=1, idex_en=1 both cycles.
- PERF_CNT_EN: run the D-wait scenario -> stall_cycles=3 (4 with a following load-use stall), flush_events=1. Reset mid-run -> both 0.
